// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field layout and fetch FSM states.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'b0000;
  localparam logic [3:0] ARITH  = 4'b0001;
  localparam logic [3:0] LOGIC  = 4'b0010;
  localparam logic [3:0] SHIFT  = 4'b0011;
  localparam logic [3:0] ROTATE = 4'b0100;
  localparam logic [3:0] LOAD   = 4'b0101;
  localparam logic [3:0] STORE  = 4'b0110;
  localparam logic [3:0] BRA    = 4'b0111;
  localparam logic [3:0] BRR    = 4'b1000;
  localparam logic [3:0] BNE    = 4'b1001;
  localparam logic [3:0] BNR    = 4'b1010;
  localparam logic [3:0] JPA    = 4'b1011;
  localparam logic [3:0] JPR    = 4'b1100;
  localparam logic [3:0] HLT    = 4'b1111;

  localparam logic [3:0] am_imm = 4'b1000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MM_MSB     = 27;
  localparam int MM_LSB     = 24;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_FULL = 2'd2,
    F_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC arithmetic: sequential increment, absolute target or PC-relative target.
module sisc_pc_next #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              pc_sel,
  input  logic              br_sel,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] imm_low;

  // Sign-extending imm and reducing mod 2^ADDR_W leaves exactly its low ADDR_W bits.
  assign imm_low = imm[ADDR_W-1:0];

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (pc_sel) begin
      if (br_sel) pc_next = imm_low;
      else        pc_next = pc + imm_low;
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch: program counter, single-outstanding imem reads and a
// one-word prefetch buffer feeding the instruction register.
//
// state  | meaning
// F_IDLE | nothing outstanding, buffer empty
// F_WAIT | request outstanding, its data is wanted
// F_FULL | buffer holds the word at pc
// F_DROP | stale request outstanding, its data is discarded
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ir_load,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               pc_rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               fetch_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] buf_q;
  logic [ADDR_W-1:0]  pc_target, pc_d;
  logic               redirect, load_acc, req_d, buf_we;

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign mm     = instr[MM_MSB:MM_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

  assign redirect = pc_rst | (pc_write & pc_sel);
  assign load_acc = ir_load & (state_q == F_FULL);

  sisc_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc      (pc),
    .imm     (imm),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .pc_next (pc_target)
  );

  // A sequential increment only takes effect together with an accepted load.
  always_comb begin
    pc_d = pc;
    if (pc_rst)                               pc_d = '0;
    else if (pc_write && (pc_sel || load_acc)) pc_d = pc_target;
  end

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (!redirect) begin
          req_d   = 1'b1;
          state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_valid) begin
          buf_we  = !redirect;
          state_d = redirect ? F_IDLE : F_FULL;
        end else if (redirect) begin
          state_d = F_DROP;
        end
      end
      F_FULL: begin
        if (redirect || load_acc) state_d = F_IDLE;
      end
      F_DROP: begin
        if (imem_valid) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= F_IDLE;
      pc          <= '0;
      instr       <= '0;
      buf_q       <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      fetch_ready <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      imem_req    <= req_d;
      fetch_ready <= (state_d == F_FULL);
      if (req_d)    imem_addr <= pc;
      if (buf_we)   buf_q     <= imem_rdata;
      if (load_acc) instr     <= buf_q;
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed and randomized bench for sisc_fetch against a transaction-level fetch model.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_load = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, pc_rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        fetch_ready;
  logic [15:0] pc;
  logic [31:0] instr;
  logic [3:0]  opcode, mm;
  logic [15:0] imm;

  int checks = 0;
  int errors = 0;

  sisc_fetch #(.ADDR_W(16), .INSTR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .br_sel      (br_sel),
    .pc_rst      (pc_rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .fetch_ready (fetch_ready),
    .pc          (pc),
    .instr       (instr),
    .opcode      (opcode),
    .mm          (mm),
    .imm         (imm)
  );

  always #5 clk = ~clk;

  // memory: sparse contents, one pending response with a countdown
  logic [31:0] mem [logic [15:0]];
  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_paddr = 16'h0;

  // reference model of the fetch unit, in terms of pc / instruction / buffer / outstanding read
  logic [15:0] m_pc, m_addr;
  logic [31:0] m_instr, m_buf;
  bit          m_ready, m_busy, m_stale, m_req;

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_addr = 16'h0; m_instr = 32'h0; m_buf = 32'h0;
    m_ready = 0; m_busy = 0; m_stale = 0; m_req = 0;
  endtask

  // Apply the rules for one rising edge using the inputs presented right now.
  task automatic model_edge();
    bit          redirect, accept;
    logic [15:0] imm_c, npc;
    redirect = pc_rst || (pc_write && pc_sel);
    accept   = ir_load && m_ready;
    imm_c    = m_instr[15:0];
    npc      = m_pc;
    if (pc_rst) npc = 16'h0;
    else if (pc_write && pc_sel) begin
      if (br_sel) npc = imm_c;
      else        npc = 16'((int'(m_pc) + int'($signed(imm_c))) & 32'hFFFF);
    end else if (accept && pc_write) npc = 16'((int'(m_pc) + 1) % 65536);
    m_req = 0;
    if (accept) m_instr = m_buf;
    if (m_busy) begin
      if (imem_valid) begin
        m_busy = 0;
        if (!m_stale && !redirect) begin
          m_ready = 1;
          m_buf   = imem_rdata;
        end
      end else if (redirect) m_stale = 1;
    end else if (m_ready) begin
      if (redirect || accept) m_ready = 0;
    end else if (!redirect) begin
      m_busy = 1; m_stale = 0; m_req = 1; m_addr = m_pc;
    end
    m_pc = npc;
  endtask

  task automatic mem_step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_rd(mem_paddr);
        mem_pend   = 1'b0;
      end
    end
    if (imem_req) begin
      chk("one_outstanding", 32'(mem_pend), 32'h0);
      mem_pend  = 1'b1;
      mem_cnt   = lat;
      mem_paddr = imem_addr;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"},    32'(pc),          32'(m_pc));
    chk({tag, ".instr"}, instr,            m_instr);
    chk({tag, ".op"},    32'(opcode),      32'(m_instr[31:28]));
    chk({tag, ".mm"},    32'(mm),          32'(m_instr[27:24]));
    chk({tag, ".imm"},   32'(imm),         32'(m_instr[15:0]));
    chk({tag, ".rdy"},   32'(fetch_ready), 32'(m_ready));
    chk({tag, ".req"},   32'(imem_req),    32'(m_req));
    chk({tag, ".addr"},  32'(imem_addr),   32'(m_addr));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    mem_step();
    check_state(tag);
  endtask

  task automatic clear_inputs();
    ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; pc_rst = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    clear_inputs();
    #1;
    model_reset();
    check_state("reset");
    repeat (n) begin
      @(posedge clk);
      #1;
      mem_step();
    end
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!fetch_ready && n < 20) begin
      cycle(tag);
      n++;
    end
    chk({tag, ".ready_seen"}, 32'(fetch_ready), 32'h1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      cycle(tag);
      n++;
    end while (!imem_req && n < 20);
    chk({tag, ".req_seen"}, 32'(imem_req), 32'h1);
  endtask

  task automatic load_seq(input string tag);
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    cycle(tag);
    clear_inputs();
  endtask

  initial begin
    logic [31:0] saved_instr;
    mem[16'h0000] = 32'h81230005;
    mem[16'h0003] = 32'h30000040;
    mem[16'h0004] = 32'h2000FFFE;
    mem[16'h0040] = 32'h7000FFFF;
    mem[16'h9999] = 32'hDEADBEEF;

    // reset and first request
    apply_reset(2);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    cycle("first");
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", 32'(imem_addr), 32'h0);

    // sequential fetch, 1-cycle memory
    cycle("lat1_a");
    chk("lat1_not_yet", 32'(fetch_ready), 32'h0);
    cycle("lat1_b");
    chk("lat1_ready", 32'(fetch_ready), 32'h1);
    load_seq("seq_load");
    chk("seq_instr", instr, 32'h81230005);
    chk("seq_opcode", 32'(opcode), 32'h8);
    chk("seq_mm", 32'(mm), 32'h1);
    chk("seq_pc", 32'(pc), 32'h1);
    cycle("seq_next");
    chk("seq_next_addr", 32'(imem_addr), 32'h1);

    // walk to pc=5 with instr imm=0xFFFE, then relative branch from FULL
    repeat (4) begin
      wait_ready("walk");
      load_seq("walk_load");
    end
    wait_ready("pre_rel");
    chk("pre_rel_pc", 32'(pc), 32'h5);
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
    cycle("rel_br");
    clear_inputs();
    chk("rel_pc", 32'(pc), 32'h3);
    chk("rel_flush", 32'(fetch_ready), 32'h0);
    cycle("rel_req");
    chk("rel_req_addr", 32'(imem_addr), 32'h3);

    // absolute branch while a 3-cycle read is outstanding
    wait_ready("abs_prep");
    load_seq("abs_prep_load");
    lat = 3;
    cycle("abs_issue");
    chk("abs_in_wait", 32'(imem_req), 32'h1);
    saved_instr = instr;
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    cycle("abs_br");
    clear_inputs();
    chk("abs_pc", 32'(pc), 32'h40);
    wait_req("abs_req");
    chk("abs_req_addr", 32'(imem_addr), 32'h40);
    chk("abs_instr_hold", instr, saved_instr);

    // load request while still waiting is ignored
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    cycle("early_load");
    clear_inputs();
    chk("early_instr", instr, saved_instr);
    chk("early_pc", 32'(pc), 32'h40);
    wait_ready("late");
    load_seq("late_load");
    chk("late_instr", instr, 32'h7000FFFF);
    chk("late_pc", 32'(pc), 32'h41);
    lat = 1;

    // jump to 0xFFFF and wrap on the sequential increment
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    cycle("to_ffff");
    clear_inputs();
    chk("ffff_pc", 32'(pc), 32'hFFFF);
    wait_req("ffff_req");
    chk("ffff_addr", 32'(imem_addr), 32'hFFFF);
    wait_ready("ffff_rdy");
    load_seq("wrap_load");
    chk("wrap_pc", 32'(pc), 32'h0);
    cycle("wrap_req");
    chk("wrap_req_addr", 32'(imem_addr), 32'h0);

    // async reset during WAIT; a late response right after release must be ignored
    mem_pend = 1'b1; mem_cnt = 2; mem_paddr = 16'h9999;
    apply_reset(2);
    chk("mid_rst_ready", 32'(fetch_ready), 32'h0);
    chk("late_rsp_present", 32'(imem_valid), 32'h1);
    cycle("post_rst");
    chk("post_rst_req", 32'(imem_req), 32'h1);
    chk("post_rst_addr", 32'(imem_addr), 32'h0);
    wait_ready("post_rst_rdy");
    chk("post_rst_instr", instr, 32'h0);
    load_seq("post_rst_load");
    chk("post_rst_loaded", instr, 32'h81230005);

    // randomized control traffic and memory latency
    for (int i = 0; i < 600; i++) begin
      ir_load  = ($urandom_range(0, 1) == 1);
      pc_write = ($urandom_range(0, 3) != 0);
      pc_sel   = ($urandom_range(0, 9) == 0);
      br_sel   = ($urandom_range(0, 1) == 1);
      pc_rst   = ($urandom_range(0, 49) == 0);
      lat      = int'($urandom_range(1, 4));
      cycle("rand");
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
